// File: rtl/uart_rx_core_if.sv
// Signal bundle between the RXD pin side / FIFO writer and the UART receive core.
// master drives the line and abort; slave is the receiver core.
interface uart_rx_core_if;
  logic       rxd;
  logic       clear;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       idle;

  modport master (
    output rxd, clear,
    input  data, data_valid, frame_err, parity_err, idle
  );

  modport slave (
    input  rxd, clear,
    output data, data_valid, frame_err, parity_err, idle
  );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampled 8N1 UART receiver with 2-of-3 mid-bit voting, false-start rejection and framing check.
// Define UART_RX_PARITY_EN to receive an even-parity bit between the data bits and the stop bit.
module uart_rx_core #(
  parameter int CLK_FREQ   = 80_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_core_if.slave rx_io
);
  localparam int DIV = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_V0     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_V2     = SW'(OVERSAMPLE / 2 + 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_rx_core: DIV=%0d, must be at least 2", DIV);
  end
  if ((OVERSAMPLE % 2 != 0) || (OVERSAMPLE < 8)) begin : g_bad_os
    $error("uart_rx_core: OVERSAMPLE=%0d, must be even and at least 8", OVERSAMPLE);
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t          state_q, state_d;
  logic            sync1_q, rxs_q;
  logic [DW-1:0]   div_q, div_d;
  logic [SW-1:0]   s_q, s_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      v_q, v_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            dv_q, dv_d;
  logic            fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            pe_q, pe_d;
`endif

  logic tick, vote, vote_tick, end_tick;

  assign tick      = (div_q == DIV_LAST);
  assign vote      = (v_q[0] & v_q[1]) | (v_q[0] & rxs_q) | (v_q[1] & rxs_q);
  assign vote_tick = tick && (s_q == S_V2);
  assign end_tick  = tick && (s_q == S_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    s_d     = s_q;
    bit_d   = bit_q;
    v_d     = v_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = 1'b0;
`endif

    if (state_q != IDLE && state_q != BREAK) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        s_d = (s_q == S_LAST) ? '0 : s_q + 1'b1;
        if (s_q == S_V0) v_d[0] = rxs_q;
        if (s_q == S_V1) v_d[1] = rxs_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          bit_d   = '0;
        end
      end
      START: begin
        if (vote_tick && vote) state_d = IDLE;
        else if (end_tick) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (vote_tick) shift_d = {vote, shift_q[7:1]};
        if (end_tick) begin
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (vote_tick) par_d = vote;
        if (end_tick) state_d = STOP;
      end
`endif
      // Stop bit is decided at its vote so the next start edge can be caught with no idle gap.
      STOP: begin
        if (vote_tick) begin
          if (vote) begin
            data_d  = shift_q;
            dv_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
            pe_d    = (par_q != ^shift_q);
`endif
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE || state_d == BREAK || state_q == IDLE) begin
      div_d = '0;
      s_d   = '0;
    end

    if (rx_io.clear) begin
      state_d = IDLE;
      div_d   = '0;
      s_d     = '0;
      bit_d   = '0;
      data_d  = data_q;
      dv_d    = 1'b0;
      fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      div_q   <= '0;
      s_q     <= '0;
      bit_q   <= '0;
      v_q     <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= rx_io.rxd;
      rxs_q   <= sync1_q;
      div_q   <= div_d;
      s_q     <= s_d;
      bit_q   <= bit_d;
      v_q     <= v_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign rx_io.data       = data_q;
  assign rx_io.data_valid = dv_q;
  assign rx_io.frame_err  = fe_q;
  assign rx_io.idle       = (state_q == IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_io.parity_err = pe_q;
`else
  assign rx_io.parity_err = 1'b0;
`endif
endmodule
